seq_voice_ctrl: RTL and testbench

- Sequencing controller for one ddfs voice: 16-slot step pattern; each step loads the carrier word and waveform select into ddfs.
- Generates a linear attack/sustain/release amplitude envelope in Q2.14 on ddfs env, plus step-position outputs for the UI/LEDs.
- Sits between the pattern-edit logic (write port) and the ddfs instance; ddfs focw/pha are driven elsewhere.

---
 rtl/seq_voice_ctrl.sv | 158 +++++++++++++++
 tb/tb_seq_voice_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_voice_ctrl.sv
// Step sequencer for one ddfs voice: 16-slot pattern RAM, tempo/gate timing and a
// linear attack/sustain/release envelope (Q2.14). All outputs are registered.
module seq_voice_ctrl #(
  parameter int          PW      = 30,
  parameter int          TW      = 32,
  parameter logic [15:0] ENV_MAX = 16'h4000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          run,
  input  logic [TW-1:0] tempo_div,
  input  logic [TW-1:0] gate_len,
  input  logic [15:0]   atk_inc,
  input  logic [15:0]   rel_inc,
  input  logic          wr_en,
  input  logic [3:0]    wr_addr,
  input  logic [PW-1:0] wr_fccw,
  input  logic [1:0]    wr_wave,
  input  logic          wr_on,
  output logic [PW-1:0] fccw,
  output logic [1:0]    signal,
  output logic [15:0]   env,
  output logic [3:0]    step_idx,
  output logic          step_pulse,
  output logic [1:0]    env_state
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ATTACK  = 2'd1,
    ST_SUSTAIN = 2'd2,
    ST_RELEASE = 2'd3
  } env_state_t;

  logic [PW-1:0] r_slot_fccw [16];
  logic [1:0]    r_slot_wave [16];
  logic          r_slot_on   [16];

  env_state_t    r_state;
  logic          r_running;
  logic [TW-1:0] r_tick;
  logic [TW-1:0] r_gate;
  logic [3:0]    r_step_idx;
  logic          r_step_pulse;
  logic [PW-1:0] r_fccw;
  logic [1:0]    r_signal;
  logic [15:0]   r_env;

  logic [TW-1:0] w_period;
  logic          w_load;
  logic [3:0]    w_load_idx;
  logic [16:0]   w_atk_sum;
  logic [15:0]   w_env_atk;
  logic [15:0]   w_env_rel;
  logic          w_gate_hit;
  logic          w_gated;
  logic [15:0]   w_env_nxt;
  env_state_t    w_state_nxt;

  assign w_period   = (tempo_div < TW'(2)) ? TW'(2) : tempo_div;
  // The first running cycle after a stop is always the load of step 0.
  assign w_load     = run && (!r_running || (r_tick >= w_period - TW'(1)));
  assign w_load_idx = r_running ? r_step_idx + 4'd1 : 4'd0;
  assign w_atk_sum  = {1'b0, r_env} + {1'b0, atk_inc};
  assign w_env_atk  = (w_atk_sum >= {1'b0, ENV_MAX}) ? ENV_MAX : w_atk_sum[15:0];
  assign w_env_rel  = (r_env > rel_inc) ? (r_env - rel_inc) : 16'd0;
  assign w_gate_hit = (r_gate == gate_len);
  assign w_gated    = (r_state == ST_ATTACK) || (r_state == ST_SUSTAIN);

  // Free-running envelope step; load and stop only override the next state.
  always_comb begin
    w_env_nxt   = 16'd0;
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        w_env_nxt   = 16'd0;
        w_state_nxt = ST_IDLE;
      end
      ST_ATTACK: begin
        w_env_nxt = w_env_atk;
        if (w_gate_hit)                 w_state_nxt = ST_RELEASE;
        else if (w_env_atk == ENV_MAX)  w_state_nxt = ST_SUSTAIN;
        else                            w_state_nxt = ST_ATTACK;
      end
      ST_SUSTAIN: begin
        w_env_nxt   = ENV_MAX;
        w_state_nxt = w_gate_hit ? ST_RELEASE : ST_SUSTAIN;
      end
      ST_RELEASE: begin
        w_env_nxt   = w_env_rel;
        w_state_nxt = (w_env_rel == 16'd0) ? ST_IDLE : ST_RELEASE;
      end
      default: begin
        w_env_nxt   = 16'd0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) begin
        r_slot_fccw[i] <= '0;
        r_slot_wave[i] <= 2'd0;
        r_slot_on[i]   <= 1'b0;
      end
      r_state      <= ST_IDLE;
      r_running    <= 1'b0;
      r_tick       <= '0;
      r_gate       <= '0;
      r_step_idx   <= 4'd0;
      r_step_pulse <= 1'b0;
      r_fccw       <= '0;
      r_signal     <= 2'd0;
      r_env        <= 16'd0;
    end else begin
      if (wr_en) begin
        r_slot_fccw[wr_addr] <= wr_fccw;
        r_slot_wave[wr_addr] <= wr_wave;
        r_slot_on[wr_addr]   <= wr_on;
      end
      r_env  <= w_env_nxt;
      r_gate <= (r_gate != '1) ? r_gate + TW'(1) : r_gate;
      if (!run) begin
        r_running    <= 1'b0;
        r_tick       <= '0;
        r_step_idx   <= 4'd0;
        r_step_pulse <= 1'b0;
        r_state      <= w_gated ? ST_RELEASE : w_state_nxt;
      end else if (w_load) begin
        r_running    <= 1'b1;
        r_tick       <= '0;
        r_gate       <= '0;
        r_step_idx   <= w_load_idx;
        r_step_pulse <= 1'b1;
        if (r_slot_on[w_load_idx]) begin
          r_fccw   <= r_slot_fccw[w_load_idx];
          r_signal <= r_slot_wave[w_load_idx];
          r_state  <= ST_ATTACK;
        end else begin
          r_state  <= w_gated ? ST_RELEASE : w_state_nxt;
        end
      end else begin
        r_tick       <= r_tick + TW'(1);
        r_step_pulse <= 1'b0;
        r_state      <= w_state_nxt;
      end
    end
  end

  assign fccw       = r_fccw;
  assign signal     = r_signal;
  assign env        = r_env;
  assign step_idx   = r_step_idx;
  assign step_pulse = r_step_pulse;
  assign env_state  = r_state;

endmodule

// File: tb/tb_seq_voice_ctrl.sv
// Directed bench for seq_voice_ctrl: envelope shape, stepping, rests, saturation,
// legato retrigger, stop/restart, write collision and synchronous reset.
module tb_seq_voice_ctrl;

  localparam int PW = 30;
  localparam int TW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          run;
  logic [TW-1:0] tempo_div;
  logic [TW-1:0] gate_len;
  logic [15:0]   atk_inc;
  logic [15:0]   rel_inc;
  logic          wr_en;
  logic [3:0]    wr_addr;
  logic [PW-1:0] wr_fccw;
  logic [1:0]    wr_wave;
  logic          wr_on;
  logic [PW-1:0] fccw;
  logic [1:0]    signal;
  logic [15:0]   env;
  logic [3:0]    step_idx;
  logic          step_pulse;
  logic [1:0]    env_state;

  int n_cmp = 0;
  int n_err = 0;

  seq_voice_ctrl #(.PW(PW), .TW(TW), .ENV_MAX(16'h4000)) dut (
    .clk(clk), .reset(reset), .run(run), .tempo_div(tempo_div), .gate_len(gate_len),
    .atk_inc(atk_inc), .rel_inc(rel_inc), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_fccw(wr_fccw), .wr_wave(wr_wave), .wr_on(wr_on), .fccw(fccw), .signal(signal),
    .env(env), .step_idx(step_idx), .step_pulse(step_pulse), .env_state(env_state)
  );

  always #5 clk = ~clk;

  // Advance one edge; outputs are then stable and inputs may be changed.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    run   = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic write_slot(input logic [3:0] a, input logic [PW-1:0] f,
                            input logic [1:0] w, input logic on);
    wr_en = 1'b1; wr_addr = a; wr_fccw = f; wr_wave = w; wr_on = on;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic check_outs(input string tag, input logic [3:0] idx, input logic pulse,
                            input logic [1:0] st, input logic [15:0] e);
    check({tag, "_idx"},   32'(step_idx),   32'(idx));
    check({tag, "_pulse"}, 32'(step_pulse), 32'(pulse));
    check({tag, "_state"}, 32'(env_state),  32'(st));
    check({tag, "_env"},   32'(env),        32'(e));
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; tempo_div = '0; gate_len = '0; atk_inc = '0; rel_inc = '0;
    wr_en = 1'b0; wr_addr = '0; wr_fccw = '0; wr_wave = '0; wr_on = 1'b0;
    ticks(2);
    check("rst_fccw", 32'(fccw), 32'h0);
    check("rst_sig", 32'(signal), 32'h0);
    check_outs("rst", 4'd0, 1'b0, 2'd0, 16'h0000);
    reset = 1'b0;

    // Basic note: T=8, gate 5
    write_slot(4'd0, 30'h0010_0000, 2'd1, 1'b1);
    tempo_div = 8; gate_len = 5; atk_inc = 16'h1000; rel_inc = 16'h0800; run = 1'b1;
    tick();
    check_outs("b_e0", 4'd0, 1'b1, 2'd1, 16'h0000);
    check("b_e0_fccw", 32'(fccw), 32'h0010_0000);
    check("b_e0_sig", 32'(signal), 32'd1);
    tick(); check_outs("b_e1", 4'd0, 1'b0, 2'd1, 16'h1000);
    tick(); check("b_e2_env", 32'(env), 32'h2000);
    tick(); check("b_e3_env", 32'(env), 32'h3000);
    tick(); check_outs("b_e4", 4'd0, 1'b0, 2'd2, 16'h4000);
    tick(); check_outs("b_e5", 4'd0, 1'b0, 2'd2, 16'h4000);
    tick(); check_outs("b_e6", 4'd0, 1'b0, 2'd3, 16'h4000);
    tick(); check_outs("b_e7", 4'd0, 1'b0, 2'd3, 16'h3800);
    tick(); check_outs("b_e8", 4'd1, 1'b1, 2'd3, 16'h3000);
    check("b_e8_fccw", 32'(fccw), 32'h0010_0000);
    ticks(5); check("b_e13_env", 32'(env), 32'h0800);
    tick(); check_outs("b_e14", 4'd1, 1'b0, 2'd0, 16'h0000);
    run = 1'b0;
    tick(); check("b_stop_idx", 32'(step_idx), 32'd0);

    // Wrap and rests: only slot 15 active, T=4
    do_reset();
    write_slot(4'd15, 30'h000A_BCDE, 2'd0, 1'b1);
    tempo_div = 4; gate_len = 2; atk_inc = 16'h2000; rel_inc = 16'h1000; run = 1'b1;
    for (int s = 0; s < 15; s++) begin
      tick();
      check("w_idx", 32'(step_idx), 32'(s));
      check("w_pulse", 32'(step_pulse), 32'd1);
      check("w_env", 32'(env), 32'h0);
      check("w_fccw", 32'(fccw), 32'h0);
      tick();
      check("w_nopulse", 32'(step_pulse), 32'd0);
      ticks(2);
    end
    tick();
    check_outs("w15_e0", 4'd15, 1'b1, 2'd1, 16'h0000);
    check("w15_fccw", 32'(fccw), 32'h000A_BCDE);
    check("w15_sig", 32'(signal), 32'd0);
    tick(); check_outs("w15_e1", 4'd15, 1'b0, 2'd1, 16'h2000);
    tick(); check_outs("w15_e2", 4'd15, 1'b0, 2'd2, 16'h4000);
    tick(); check_outs("w15_e3", 4'd15, 1'b0, 2'd3, 16'h4000);
    tick(); check_outs("w0_wrap", 4'd0, 1'b1, 2'd3, 16'h3000);
    check("w0_fccw_hold", 32'(fccw), 32'h000A_BCDE);
    run = 1'b0;
    tick(); check_outs("w_stop", 4'd0, 1'b0, 2'd3, 16'h2000);

    // Saturation in both directions
    do_reset();
    write_slot(4'd0, 30'h0000_1234, 2'd0, 1'b1);
    tempo_div = 16; gate_len = 2; atk_inc = 16'h3000; rel_inc = 16'h3000; run = 1'b1;
    tick(); check_outs("s_e0", 4'd0, 1'b1, 2'd1, 16'h0000);
    tick(); check_outs("s_e1", 4'd0, 1'b0, 2'd1, 16'h3000);
    tick(); check_outs("s_e2", 4'd0, 1'b0, 2'd2, 16'h4000);
    tick(); check_outs("s_e3", 4'd0, 1'b0, 2'd3, 16'h4000);
    tick(); check_outs("s_e4", 4'd0, 1'b0, 2'd3, 16'h1000);
    tick(); check_outs("s_e5", 4'd0, 1'b0, 2'd0, 16'h0000);
    run = 1'b0;

    // Legato retrigger, stop mid-sustain, restart with tempo_div=0
    do_reset();
    write_slot(4'd0, 30'h0000_1000, 2'd1, 1'b1);
    write_slot(4'd1, 30'h0000_2000, 2'd0, 1'b1);
    tempo_div = 4; gate_len = 32'hFFFF_FFFF; atk_inc = 16'h4000; rel_inc = 16'h0800; run = 1'b1;
    tick(); check_outs("l_e0", 4'd0, 1'b1, 2'd1, 16'h0000);
    tick(); check_outs("l_e1", 4'd0, 1'b0, 2'd2, 16'h4000);
    ticks(2); check_outs("l_e3", 4'd0, 1'b0, 2'd2, 16'h4000);
    tick(); check_outs("l_e4", 4'd1, 1'b1, 2'd1, 16'h4000);
    check("l_e4_fccw", 32'(fccw), 32'h0000_2000);
    check("l_e4_sig", 32'(signal), 32'd0);
    tick(); check_outs("l_e5", 4'd1, 1'b0, 2'd2, 16'h4000);
    run = 1'b0;
    tick(); check_outs("l_stop", 4'd0, 1'b0, 2'd3, 16'h4000);
    tick(); check_outs("l_rel", 4'd0, 1'b0, 2'd3, 16'h3800);
    run = 1'b1; tempo_div = 0;
    tick();
    check("l_rs_idx", 32'(step_idx), 32'd0);
    check("l_rs_pulse", 32'(step_pulse), 32'd1);
    check("l_rs_state", 32'(env_state), 32'd1);
    check("l_rs_fccw", 32'(fccw), 32'h0000_1000);
    tick(); check_outs("l_rs1", 4'd0, 1'b0, 2'd2, 16'h4000);
    tick(); check_outs("l_rs2", 4'd1, 1'b1, 2'd1, 16'h4000);
    check("l_rs2_fccw", 32'(fccw), 32'h0000_2000);
    run = 1'b0;

    // Write collision on the loading slot, then reset mid-attack
    do_reset();
    write_slot(4'd3, 30'h0000_0333, 2'd1, 1'b1);
    tempo_div = 4; gate_len = 1; atk_inc = 16'h0100; rel_inc = 16'h4000; run = 1'b1;
    tick(); check("c_e0_pulse", 32'(step_pulse), 32'd1);
    ticks(11);
    wr_en = 1'b1; wr_addr = 4'd3; wr_fccw = 30'h0000_0777; wr_wave = 2'd0; wr_on = 1'b1;
    tick();
    wr_en = 1'b0;
    check_outs("c_e12", 4'd3, 1'b1, 2'd1, 16'h0000);
    check("c_e12_fccw", 32'(fccw), 32'h0000_0333);
    check("c_e12_sig", 32'(signal), 32'd1);
    ticks(63);
    check_outs("c_e75", 4'd2, 1'b0, 2'd0, 16'h0000);
    tick();
    check_outs("c_e76", 4'd3, 1'b1, 2'd1, 16'h0000);
    check("c_e76_fccw", 32'(fccw), 32'h0000_0777);
    check("c_e76_sig", 32'(signal), 32'd0);
    tick(); check_outs("c_e77", 4'd3, 1'b0, 2'd1, 16'h0100);
    reset = 1'b1;
    tick();
    check_outs("c_rst", 4'd0, 1'b0, 2'd0, 16'h0000);
    check("c_rst_fccw", 32'(fccw), 32'h0);
    check("c_rst_sig", 32'(signal), 32'h0);
    reset = 1'b0; run = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
